// File: rtl/onewire_master_tx.sv
// onewire_master_tx
// Bus-master transmit engine for the 1-wire link. It produces the
// reset/presence sequence and writes bytes as LSB-first write time slots.
// The engine only pulls the open-drain line low. The top level maps
// line_drive onto the pad as data_line = line_drive ? 0 : z.
// line_in is the already synchronised bus level and is used only to sample
// presence. All durations are counted in clock cycles.
module onewire_master_tx #(
  parameter logic [15:0] T_RSTL = 16'd48000,  // reset pulse low time
  parameter logic [15:0] T_RSTH = 16'd48000,  // release window after the reset pulse
  parameter logic [15:0] T_PDS  = 16'd7000,   // presence sample index inside the release window
  parameter logic [15:0] T_SLOT = 16'd7000,   // write slot length from the falling edge
  parameter logic [15:0] T_LOW1 = 16'd600,    // low time of a write-1
  parameter logic [15:0] T_LOW0 = 16'd6000,   // low time of a write-0
  parameter logic [15:0] T_REC  = 16'd1000    // recovery time after each slot
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_reset,
  input  logic       start_write,
  input  logic [7:0] tx_byte,
  input  logic       line_in,
  output logic       line_drive,
  output logic       busy,
  output logic       done,
  output logic       presence
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_LOW  = 3'd1,
    RST_HIGH = 3'd2,
    BIT_LOW  = 3'd3,
    BIT_HIGH = 3'd4,
    BIT_REC  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_s;
  logic        presence_r;
  logic        presence_s;
  logic        line_drive_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] low_len_s;

  // Low-phase length of the current slot depends on the bit being sent (LSB of the shifter).
  always_comb begin
    if (shift_r[0]) begin
      low_len_s = T_LOW1;
    end else begin
      low_len_s = T_LOW0;
    end
  end

  // Next-state, counter, bit index, shifter and presence computation.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    shift_s    = shift_r;
    presence_s = presence_r;
    case (state_r)
      IDLE: begin
        cnt_s = 16'd0;
        // start_reset has priority; a simultaneous write request is dropped.
        if (start_reset) begin
          state_s    = RST_LOW;
          presence_s = 1'b0;
        end else if (start_write) begin
          state_s = BIT_LOW;
          shift_s = tx_byte;
          idx_s   = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      RST_LOW: begin
        if (cnt_r == (T_RSTL - 16'd1)) begin
          state_s = RST_HIGH;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      RST_HIGH: begin
        // A device answering pulls the line low at the sample point.
        if (cnt_r == T_PDS) begin
          presence_s = ~line_in;
        end else begin
          presence_s = presence_r;
        end
        if (cnt_r == (T_RSTH - 16'd1)) begin
          state_s = IDLE;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      BIT_LOW: begin
        // The slot counter keeps running into BIT_HIGH so the slot length is measured from the falling edge.
        cnt_s = cnt_r + 16'd1;
        if (cnt_r == (low_len_s - 16'd1)) begin
          state_s = BIT_HIGH;
        end else begin
          state_s = BIT_LOW;
        end
      end
      BIT_HIGH: begin
        if (cnt_r == (T_SLOT - 16'd1)) begin
          state_s = BIT_REC;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      BIT_REC: begin
        if (cnt_r == (T_REC - 16'd1)) begin
          cnt_s = 16'd0;
          if (idx_r == 3'd7) begin
            state_s = IDLE;
          end else begin
            state_s = BIT_LOW;
            idx_s   = idx_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        // An illegal encoding returns to IDLE with the bus released.
        state_s = IDLE;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // State, counter, bit index, shifter and presence registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      idx_r      <= 3'd0;
      shift_r    <= 8'd0;
      presence_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      shift_r    <= shift_s;
      presence_r <= presence_s;
    end
  end

  // Registered outputs decoded from the next state, so they change on the accepting edge and never glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_drive_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      line_drive_r <= (state_s == RST_LOW) || (state_s == BIT_LOW);
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_r != IDLE) && (state_s == IDLE);
    end
  end

  assign line_drive = line_drive_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign presence   = presence_r;

endmodule

// File: tb/tb_onewire_master_tx.sv
// Testbench for onewire_master_tx with shortened timing parameters.
// Each operation's waveform (line_drive, busy, done, presence) is predicted
// cycle by cycle from the timing rules and compared with the design's outputs.
module tb_onewire_master_tx;

  localparam int RSTL = 40;
  localparam int RSTH = 36;
  localparam int PDS  = 10;
  localparam int SLOT = 20;
  localparam int LOW1 = 3;
  localparam int LOW0 = 12;
  localparam int REC  = 5;
  localparam int RST_LEN = RSTL + RSTH;
  localparam int WR_LEN  = 8 * (SLOT + REC);
  localparam int D_R = RST_LEN + 1;
  localparam int D_W = WR_LEN + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_reset = 1'b0;
  logic       start_write = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       line_in = 1'b1;
  logic       line_drive;
  logic       busy;
  logic       done;
  logic       presence;

  int   total = 0;
  int   bad = 0;
  logic model_pres = 1'b0;

  onewire_master_tx #(
    .T_RSTL(16'd40), .T_RSTH(16'd36), .T_PDS(16'd10), .T_SLOT(16'd20),
    .T_LOW1(16'd3), .T_LOW0(16'd12), .T_REC(16'd5)
  ) dut (
    .clock(clock), .reset(reset), .start_reset(start_reset), .start_write(start_write),
    .tx_byte(tx_byte), .line_in(line_in), .line_drive(line_drive), .busy(busy),
    .done(done), .presence(presence)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         sr;
    bit         sw;
    logic [7:0] data;
    int         a;
    int         b;
    bit         noise;
    int         gap;
    logic       exp_pres;
    int         exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Idle period: bus released, no busy/done, presence held.
  task automatic idle_check(input int n, input string name, input bit rnd);
    int mism = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (line_drive !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || presence !== model_pres) mism++;
      if (rnd) begin
        tx_byte = 8'($urandom);
        line_in = 1'($urandom);
      end else begin
        line_in = 1'b1;
      end
    end
    check(name, mism, 0);
  endtask

  // Run one operation starting at the current negedge, compare its whole waveform.
  // Returns the cycle in which done was seen (-1 if never) and presence at that time.
  task automatic run_op(input string name, input bit sr, input bit sw, input logic [7:0] data,
                        input int a, input int b, input bit noise,
                        output int done_at, output logic pres_at_done);
    bit   e_ld [0:255];
    logic e_pr [0:255];
    bit   is_rst;
    bit   dev;
    int   len;
    int   mism;
    int   first_bad;
    logic pres_new;
    is_rst = sr;
    pres_new = model_pres;
    for (int k = 0; k < 256; k++) begin
      e_ld[k] = 1'b0;
      e_pr[k] = model_pres;
    end
    if (is_rst) begin
      len = RST_LEN;
      pres_new = (a <= PDS) && (PDS <= b);
      for (int k = 1; k <= len + 1; k++) begin
        e_ld[k] = (k <= RSTL);
        e_pr[k] = (k >= RSTL + PDS + 2) ? pres_new : 1'b0;
      end
    end else begin
      len = WR_LEN;
      for (int j = 0; j < 8; j++) begin
        int k0;
        int low;
        k0 = 1 + j * (SLOT + REC);
        low = data[j] ? LOW1 : LOW0;
        for (int k = k0; k < k0 + low; k++) e_ld[k] = 1'b1;
      end
    end
    start_reset = sr;
    start_write = sw;
    tx_byte = data;
    line_in = 1'b1;
    @(posedge clock);
    mism = 0;
    first_bad = -1;
    done_at = -1;
    pres_at_done = 1'bx;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clock);
      if (line_drive !== e_ld[k] || busy !== (k <= len) || done !== (k == len + 1) ||
          presence !== e_pr[k]) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
      if (done === 1'b1 && done_at < 0) begin
        done_at = k;
        pres_at_done = presence;
      end
      dev = is_rst && ((k - (RSTL + 1)) >= a) && ((k - (RSTL + 1)) <= b);
      line_in = (line_drive || dev) ? 1'b0 : 1'b1;
      if (k <= len && noise) begin
        start_reset = 1'($urandom);
        start_write = 1'($urandom);
        tx_byte = 8'($urandom);
      end else begin
        start_reset = 1'b0;
        start_write = 1'b0;
      end
    end
    model_pres = pres_new;
    check($sformatf("%s wave (first bad cycle %0d)", name, first_bad), mism, 0);
  endtask

  initial begin
    int   done_at;
    logic pres_at;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 3,  30, 1'b0, 2, 1'b1, D_R};
    vecs[1] = '{1'b0, 1'b1, 8'hA5, -1, -1, 1'b0, 0, 1'b1, D_W};
    vecs[2] = '{1'b1, 1'b0, 8'h00, -1, -1, 1'b0, 3, 1'b0, D_R};
    vecs[3] = '{1'b1, 1'b1, 8'h5A, 5,  20, 1'b1, 0, 1'b1, D_R};
    vecs[4] = '{1'b0, 1'b1, 8'h3C, -1, -1, 1'b1, 1, 1'b1, D_W};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 12, 20, 1'b0, 0, 1'b0, D_R};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 10, 10, 1'b0, 2, 1'b1, D_R};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 0,  9,  1'b0, 0, 1'b0, D_R};

    // Power-up in reset.
    repeat (3) @(negedge clock);
    check("reset line_drive", line_drive, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset presence", presence, 0);
    reset = 1'b1;
    idle_check(1000, "idle after reset", 1'b1);
    line_in = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < vecs[i].gap; g++) @(negedge clock);
      run_op($sformatf("vec%0d", i), vecs[i].sr, vecs[i].sw, vecs[i].data, vecs[i].a, vecs[i].b,
             vecs[i].noise, done_at, pres_at);
      check($sformatf("vec%0d done cycle", i), done_at, vecs[i].exp_done);
      check($sformatf("vec%0d presence", i), pres_at, vecs[i].exp_pres);
    end
    idle_check(5, "idle after table", 1'b0);

    // Reset in the middle of bit 3's low phase of a 0x00 write.
    start_write = 1'b1;
    tx_byte = 8'h00;
    @(posedge clock);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      start_write = 1'b0;
      line_in = line_drive ? 1'b0 : 1'b1;
    end
    check("mid bit3 line_drive", line_drive, 1);
    #2 reset = 1'b0;
    #1;
    check("async release line_drive", line_drive, 0);
    check("async busy", busy, 0);
    model_pres = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    line_in = 1'b1;
    idle_check(20, "idle after mid reset", 1'b0);
    run_op("write FF", 1'b0, 1'b1, 8'hFF, -1, -1, 1'b0, done_at, pres_at);
    check("write FF done cycle", done_at, D_W);

    // Randomized operations against the model.
    for (int i = 0; i < 8; i++) begin
      bit   r_sr;
      bit   r_sw;
      int   ra;
      int   rb;
      int   gap;
      logic [7:0] rd;
      r_sr = 1'($urandom);
      r_sw = r_sr ? 1'($urandom) : 1'b1;
      rd = 8'($urandom);
      ra = int'($urandom_range(0, 30));
      rb = ra + int'($urandom_range(0, 10));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) @(negedge clock);
      run_op($sformatf("rand%0d", i), r_sr, r_sw, rd, ra, rb, 1'b1, done_at, pres_at);
      check($sformatf("rand%0d done cycle", i), done_at, r_sr ? D_R : D_W);
    end
    idle_check(10, "final idle", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onewire_master_tx.md
# onewire_master_tx

Bus-master transmit engine for the 1-wire link. It generates the reset/presence sequence and writes bytes as LSB-first write time slots by driving the open-drain data line low. It sits beside the debounced receive path in the top level: it owns the pull-down enable for `data_line` and samples the already-synchronised line level for presence detection. All timing is in clock cycles; the defaults assume the 100 MHz system clock.

## Interface
- `T_RSTL`, 16'd48000: reset pulse low time (480 µs).
- `T_RSTH`, 16'd48000: release window after the reset pulse (480 µs).
- `T_PDS`, 16'd7000: presence sample point, counted from the release (70 µs).
- `T_SLOT`, 16'd7000: write slot length, counted from the slot's falling edge (70 µs).
- `T_LOW1`, 16'd600: low time for a write-1 (6 µs).
- `T_LOW0`, 16'd6000: low time for a write-0 (60 µs).
- `T_REC`, 16'd1000: recovery time after each slot (10 µs).
- Parameter constraints: all parameters ≥1; `T_LOW1` < `T_LOW0` < `T_SLOT`; `T_PDS` < `T_RSTH`.
- `clock`, input, 1: the single clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start_reset`, input, 1: request a reset/presence sequence; sampled only in IDLE.
- `start_write`, input, 1: request a byte write; sampled only in IDLE.
- `tx_byte`, input, 8: byte to send; latched on the accepting edge.
- `line_in`, input, 1: synchronised/debounced bus level.
- `line_drive`, output, 1: 1 = pull `data_line` low; top-level maps it to `data_line = line_drive ? 0 : z`.
- `busy`, output, 1: a sequence is in progress.
- `done`, output, 1: one-cycle pulse when a sequence completes.
- `presence`, output, 1: result of the last reset sequence (1 = a device pulled the line low).

## Operation
- States: IDLE, RST_LOW, RST_HIGH, BIT_LOW, BIT_HIGH, BIT_REC. One 16-bit cycle counter and one 3-bit bit index.
- IDLE:
  - If `start_reset`=1, go to RST_LOW, clear the counter and clear `presence`.
  - Else if `start_write`=1, latch `tx_byte` into the shift register, clear the bit index and go to BIT_LOW.
  - If both are asserted together, `start_reset` wins and the write request is dropped.
  - Starts are ignored outside IDLE.
- RST_LOW: `line_drive`=1 for `T_RSTL` cycles, then go to RST_HIGH.
- RST_HIGH: `line_drive`=0 for `T_RSTH` cycles. In cycle index `T_PDS` of RST_HIGH (counting from 0), register `presence` = ~`line_in`. After the last cycle, return to IDLE.
- BIT_LOW: `line_drive`=1 for `T_LOW1` cycles if the current bit is 1, `T_LOW0` cycles if it is 0. The slot counter runs from 0 at slot start.
- BIT_HIGH: `line_drive`=0 until the slot counter reaches `T_SLOT`, then go to BIT_REC.
- BIT_REC: `line_drive`=0 for `T_REC` cycles. Then:
  - if bit index = 7, return to IDLE;
  - else increment the index, shift the register right and go to BIT_LOW.
- Bit order is LSB first. Each bit occupies exactly `T_SLOT`+`T_REC` cycles of line time.
- `line_drive` is registered and glitch-free. It is never asserted in IDLE.

## Timing
- Reset values: `line_drive`=0, `busy`=0, `done`=0, `presence`=0, state IDLE, counter 0.
- Assertion of `reset` (low) forces all outputs to their reset values asynchronously, including mid-slot; the bus is released immediately. Deassertion returns the block to IDLE.
- Start accepted on rising edge E: `line_drive`=1 and `busy`=1 from E+1.
- Reset sequence:
  - `line_drive` is high for exactly `T_RSTL` cycles;
  - `done`=1 and `busy`=0 in cycle E+`T_RSTL`+`T_RSTH`+1 (default 96001);
  - `presence` is valid from cycle E+`T_RSTL`+`T_PDS`+2 onward and holds until the next reset sequence starts.
- Byte write:
  - `done`=1 and `busy`=0 in cycle E+8·(`T_SLOT`+`T_REC`)+1 (default 64001);
  - consecutive slot falling edges are `T_SLOT`+`T_REC` cycles apart (default 8000).
- `done` is high for exactly one cycle.
- A new start can be accepted in the same cycle that `done` is high (state is already IDLE). Back-to-back operations therefore leave no extra idle gap beyond `T_REC`.
- Changes on `tx_byte` after acceptance have no effect on the byte in flight.

## Test plan
- Power-up with `reset`=0, then release: `line_drive`=0, `busy`=0, `done`=0, `presence`=0; no activity with both starts low for 1000 cycles.
- Reset sequence with the modelled device pulling `line_in` low during release cycles 1500–25500: `line_drive` high for exactly 48000 cycles; `presence`=1; `done` pulse at cycle 96001.
- Reset sequence with no device (`line_in`=1 throughout): `presence`=0 at `done`. A prior `presence`=1 is cleared when the sequence starts.
- Write 0xA5: low pulses of 600/6000 cycles in the order 1,0,1,0,0,1,0,1 (LSB first); slot starts 8000 cycles apart; `done` at cycle 64001.
- `start_reset` and `start_write` asserted together, then both re-pulsed while `busy`: only the reset sequence runs; the mid-operation starts are ignored.
- Assert `reset` in the middle of bit 3's low phase of a 0x00 write: `line_drive` falls to 0 without waiting for a clock edge; after release the block is in IDLE, and a fresh write of 0xFF completes normally.
